// File: rtl/binary_decoder.sv
// Registered binary-to-one-hot decoder: out carries the one-hot decode of
// the select sampled at the previous rising edge, or all zeros when disabled.
module binary_decoder #(
  parameter  int SEL_WIDTH = 4,
  localparam int OUT_WIDTH = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_enable,
  input  logic [SEL_WIDTH-1:0] in,
  output logic [OUT_WIDTH-1:0] out
);

  logic [OUT_WIDTH-1:0] out_d;
  logic [OUT_WIDTH-1:0] out_q;

  // Compare-based decode: an X/Z select or enable matches no bit, so the
  // register loads all zeros for unknown inputs.
  always_comb begin
    out_d = '0;
    if (load_enable) begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
        if (in == SEL_WIDTH'(i)) begin
          out_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

  a_onehot0: assert property (@(posedge clk) $onehot0(out_q));

  a_zero_after_disable: assert property (@(posedge clk) !load_enable |=> out_q == '0);

  a_onehot_when_enabled: assert property (@(posedge clk)
    (!reset && load_enable && !$isunknown(in)) |=> $onehot(out_q));

  a_inputs_known: assert property (@(posedge clk)
    !reset |-> !$isunknown({load_enable, in}));

  for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_cov_sel
    c_sel: cover property (@(posedge clk)
      !reset && load_enable && in == SEL_WIDTH'(g));
  end

endmodule

// File: tb/tb_binary_decoder.sv
// Directed plus randomized checks of binary_decoder against a shift-based
// reference model; expected values are queued per edge and popped on check.
module tb_binary_decoder;

  localparam int SW = 4;
  localparam int OW = 16;

  logic          clk;
  logic          reset;
  logic          load_enable;
  logic [SW-1:0] in;
  logic [OW-1:0] out;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_exp;
  int vectors;
  int miscompares;

  binary_decoder #(.SEL_WIDTH(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_enable (load_enable),
    .in          (in),
    .out         (out)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // Reference model: reset clears, enable selects bit 2**sel, else zero.
  function automatic logic [OW-1:0] model(input logic r, input logic en,
                                          input logic [SW-1:0] sel);
    logic [OW-1:0] one;
    one = 1;
    if (r) return '0;
    if (en) return one << sel;
    return '0;
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] observed,
                       input logic [OW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, check 1ns after the following rising edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [SW-1:0] sel);
    @(negedge clk);
    reset       = r;
    load_enable = en;
    in          = sel;
    exp_q.push_back(model(r, en, sel));
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check(tag, out, last_exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load_enable = 1'b1;
    in          = 4'h5;

    // Reset held two cycles with decode requested, then released.
    step("reset_c0", 1'b1, 1'b1, 4'h5);
    step("reset_c1", 1'b1, 1'b1, 4'h5);
    step("reset_release", 1'b0, 1'b1, 4'h5);
    check("reset_release_val", out, 16'h0020);

    for (int i = 0; i < 16; i++) step("disabled_sweep", 1'b0, 1'b0, 4'(i));

    for (int i = 0; i < 16; i++) begin
      step("full_sweep", 1'b0, 1'b1, 4'(i));
      check("full_sweep_abs", out, 16'h0001 << i);
    end

    step("wrap_15", 1'b0, 1'b1, 4'hf);
    check("wrap_15_abs", out, 16'h8000);
    step("wrap_0", 1'b0, 1'b1, 4'h0);
    check("wrap_0_abs", out, 16'h0001);
    step("wrap_disable", 1'b0, 1'b0, 4'h0);

    // Mid-operation reset; out must hold until the edge that samples reset.
    step("mid_run", 1'b0, 1'b1, 4'h9);
    check("mid_run_abs", out, 16'h0200);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_no_async", out, 16'h0200);
    exp_q.push_back(model(1'b1, 1'b1, 4'h9));
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check("mid_reset", out, last_exp);
    step("mid_resume", 1'b0, 1'b1, 4'h9);
    check("mid_resume_abs", out, 16'h0200);

    step("en_edge_before", 1'b0, 1'b0, 4'h3);
    check("en_edge_before_abs", out, 16'h0000);
    step("en_edge_after", 1'b0, 1'b1, 4'h3);
    check("en_edge_after_abs", out, 16'h0008);

    for (int n = 0; n < 300; n++) begin
      step("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: observed %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/binary_decoder.md
BINARY_DECODER -- requirements
Module: binary_decoder

Interface
REQ-001 Parameter SEL_WIDTH, default 4: width of the select input.
REQ-002 Parameter OUT_WIDTH, default 2**SEL_WIDTH (16): width of the one-hot output; the block SHALL derive it and SHALL NOT accept an override.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port out, output, OUT_WIDTH bits: registered one-hot decode result, all zeros when disabled.
REQ-006 Port in, input, SEL_WIDTH bits: binary select value.
REQ-007 Port load_enable, input, 1 bit: decode enable, active-high.

Function
REQ-008 On each rising clk edge with reset low and load_enable=1, out SHALL load a vector with only bit[in] set and all other bits cleared.
REQ-009 On each rising clk edge with reset low and load_enable=0, out SHALL load all zeros, regardless of in.
REQ-010 Latency SHALL be exactly one clock: out reflects the in/load_enable values sampled at the preceding rising edge; there is no combinational path from inputs to out.
REQ-011 out SHALL never have more than one bit set; with load_enable=1 it SHALL have exactly one bit set.
REQ-012 Every in value 0..OUT_WIDTH-1 is legal; no out-of-range case exists.
REQ-013 Wrap-around: in stepping 15 -> 0 SHALL move the set bit from out[15] to out[0] on the next edge, with no intermediate zero or double-bit cycle.
REQ-014 in changes while load_enable=0 SHALL have no effect on out.
REQ-015 When load_enable rises, out SHALL show the decode of the in sampled at that same edge.
REQ-016 If in or load_enable is X/Z at a sampling edge, out SHALL go to all zeros; a verification assertion SHALL flag the event.

Reset
REQ-017 When reset=1 at a rising clk edge, out SHALL become all zeros (16'h0000), overriding load_enable and in.
REQ-018 Reset asserted mid-operation SHALL clear out at the next edge; decoding SHALL resume at the first edge after reset deasserts, using the inputs sampled at that edge.
REQ-019 Reset SHALL have no asynchronous effect; out holds its value between edges while reset is high until the edge occurs.

Structure
REQ-020 The block SHALL be a single module with no sub-modules: a combinational shift/compare decode feeding one OUT_WIDTH-bit register.
REQ-021 No shared package SHALL be used; SEL_WIDTH and OUT_WIDTH SHALL be module parameters.
REQ-022 The RTL SHALL include assertions that out is one-hot-or-zero and zero when the previous-cycle load_enable=0, and cover points for each of the 16 select values.

Verification
REQ-023 Reset: assert reset for 2 cycles with load_enable=1 and in=4'h5 -> out=16'h0000 during reset; out=16'h0020 one edge after reset deasserts.
REQ-024 Disabled: load_enable=0, sweep in 0..15 -> out stays 16'h0000 every cycle.
REQ-025 Full sweep: load_enable=1, in increments 0..15 one per cycle -> out = 16'h0001, 16'h0002, ..., 16'h8000, each one cycle after the corresponding in.
REQ-026 Wrap and disable: in=15 then in=0 with load_enable=1 -> out=16'h8000 then 16'h0001; then drop load_enable -> out=16'h0000 on the next edge.
REQ-027 Mid-operation reset: load_enable=1, in=4'h9 (out=16'h0200); pulse reset one cycle -> out=16'h0000 for one cycle, then 16'h0200 again.
REQ-028 Enable edge: in=4'h3 with load_enable 0 -> 1 at edge N -> out=16'h0000 before edge N and 16'h0008 after edge N.
